pattern_scan_ctrl: RTL and testbench
====================================

// Module: pattern_scan_ctrl
// PURPOSE
//  Frame-level controller for serial bit-pattern detection. On start, latches a programmable pattern
//  (length 1..PAT_W) and a frame length, scans exactly that many valid input bits, and counts
//  overlapping matches. Reports a final count and a done pulse. Sits between the serial receive
//  path and the control/status logic that arms scans and reads results.
// PARAMETERS
//  PAT_W   8   maximum pattern length in bits
//  PLEN_W  4   width of cfg_plen; must hold PAT_W
//  LEN_W   16  width of cfg_frame (frame length in bits)
//  CNT_W   8   width of match_cnt
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rstn       in   1       asynchronous reset, active-low
//  start      in   1       arm a scan; sampled only in IDLE
//  abort      in   1       cancel scan in RUN
//  cfg_pat    in   PAT_W   pattern; bit 0 = most recently received bit
//  cfg_plen   in   PLEN_W  pattern length; 0 -> 1, >PAT_W -> PAT_W
//  cfg_frame  in   LEN_W   bits to scan; 0 -> immediate DONE
//  data_in    in   1       serial data bit
//  data_vld   in   1       data_in valid this cycle
//  busy       out  1       high in RUN
//  match      out  1       one-cycle pulse per detected pattern
//  match_cnt  out  CNT_W   matches in current/last frame, saturating
//  ovf        out  1       sticky: match_cnt saturated this frame
//  done       out  1       one-cycle pulse at frame end
// BEHAVIOUR
//  - Reset (rstn=0, any state, mid-scan included): state IDLE. Shift reg, bit counter, history
//    counter, match_cnt, ovf, busy, match, done all 0 immediately.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, start=1: latch cfg_pat, clamped cfg_plen, cfg_frame. Clear shift reg, bit_cnt, hist,
//    match_cnt, ovf. Next state RUN, or DONE if cfg_frame==0. busy=1 from the next cycle.
//  - start is ignored outside IDLE. data_vld is ignored outside RUN.
//  - RUN, data_vld=1:
//      shift <= {shift[PAT_W-2:0], data_in}
//      bit_cnt++
//      hist saturates at PAT_W
//  - Hit (combinational, on the new shift value): low plen bits equal cfg_pat low plen bits, and
//    hist+1 >= plen. No hit is possible on partial history.
//  - On the same edge as the shift: match <= hit; if hit, match_cnt++.
//    The match pulse appears the cycle after the completing bit (1-cycle latency).
//  - match_cnt saturates at 2^CNT_W-1. A hit at saturation sets ovf (sticky until next start).
//  - Matches overlap: each accepted bit can complete a match.
//  - When the accepted bit makes bit_cnt==cfg_frame: next state DONE.
//  - DONE (one cycle): done=1, busy=0. match_cnt is final; the last-bit match pulse coincides with
//    done. Next state IDLE.
//  - abort=1 in RUN: next state IDLE. The bit that cycle is not shifted. No done pulse.
//    match_cnt and ovf hold. abort beats a simultaneous last bit. abort is ignored in IDLE/DONE.
//  - match_cnt and ovf hold their values in IDLE until the next start.
// TESTING
//  1. Reset: rstn=0 with random inputs -> all outputs 0. Release rstn, start=0 -> outputs stay 0.
//  2. pat=3'b010, plen=3, frame=8; stream 0,1,0,1,0,0,1,0 with vld=1 every cycle
//     -> match pulses after bits 3, 5 and 8; done coincides with the bit-8 match; match_cnt=3.
//  3. Same stream as test 2 with data_vld low every other cycle -> same 3 matches;
//     done one cycle after the 8th valid bit; no shifting while vld=0.
//  4. CNT_W=2, pat=1, plen=1, frame=6, all ones -> 6 match pulses; match_cnt=3; ovf=1;
//     next start clears both.
//  5. pat=2'b00, plen=2; first bit 0 -> no match (partial history). Abort after 4 bits -> busy=0,
//     no done, match_cnt held. start while busy is ignored.
//  6. rstn pulsed low mid-RUN -> immediate IDLE, all outputs 0. plen=0 behaves as 1.
//     frame=0 -> done one cycle after start, match_cnt=0.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: frame-level serial pattern detector.
// A start in IDLE latches the pattern, its clamped length and the frame length,
// then exactly cfg_frame valid bits are scanned and overlapping matches counted.
// Input qualifier: data_in is consumed on a rising edge only when data_vld=1 and
// the FSM is in RUN; there is no back-pressure, so every such bit is accepted.
module pattern_scan_ctrl #(
  parameter int PAT_W  = 8,
  parameter int PLEN_W = 4,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [PLEN_W-1:0] cfg_plen,
  input  logic [LEN_W-1:0]  cfg_frame,
  input  logic              data_in,
  input  logic              data_vld,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              ovf,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PAT_W-1:0]    r_pat;
  logic [PLEN_W-1:0]   r_plen;
  logic [LEN_W-1:0]    r_frame;
  logic [PAT_W-1:0]    r_shift;
  logic [LEN_W-1:0]    r_bit_cnt;
  logic [PLEN_W-1:0]   r_hist;
  logic                r_match;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;

  logic [PLEN_W-1:0]   w_plen_clamp;
  logic [PAT_W-1:0]    w_mask;
  logic [PAT_W-1:0]    w_shift_nxt;
  logic                w_start_go;
  logic                w_accept;
  logic                w_last;
  logic                w_hist_ok;
  logic                w_hit;

  assign w_start_go  = (r_state == S_IDLE) && start;
  // abort wins over a bit arriving in the same cycle, so it suppresses acceptance
  assign w_accept    = (r_state == S_RUN) && data_vld && !abort;
  assign w_last      = w_accept && ((r_bit_cnt + LEN_W'(1)) == r_frame);
  assign w_shift_nxt = {r_shift[PAT_W-2:0], data_in};
  // a match needs at least plen bits of history including the incoming one
  assign w_hist_ok   = ({1'b0, r_hist} + (PLEN_W+1)'(1)) >= {1'b0, r_plen};
  assign w_hit       = w_accept && w_hist_ok &&
                       ((w_shift_nxt & w_mask) == (r_pat & w_mask));

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

  // Clamp the requested pattern length into 1..PAT_W before latching it
  always_comb begin
    w_plen_clamp = cfg_plen;
    if (cfg_plen == '0) begin
      w_plen_clamp = PLEN_W'(1);
    end else if (cfg_plen > PLEN_W'(PAT_W)) begin
      w_plen_clamp = PLEN_W'(PAT_W);
    end
  end

  // Compare mask: only the low r_plen bits of shift/pattern take part
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_plen));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (cfg_frame == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: configuration latch, shift register, counters and match pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat     <= '0;
      r_plen    <= '0;
      r_frame   <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_hist    <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (w_start_go) begin
        r_pat     <= cfg_pat;
        r_plen    <= w_plen_clamp;
        r_frame   <= cfg_frame;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_hist    <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else if (w_accept) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
        if (r_hist != PLEN_W'(PAT_W)) begin
          r_hist <= r_hist + PLEN_W'(1);
        end
        r_match <= w_hit;
        if (w_hit) begin
          if (r_cnt == '1) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl. Two instances share every input: the
// default one (8-bit count) and a narrow one (2-bit count) for saturation.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_pat = '0;
  logic [3:0]  cfg_plen = '0;
  logic [15:0] cfg_frame = '0;
  logic        data_in = 1'b0;
  logic        data_vld = 1'b0;

  logic        busy, match, ovf, done;
  logic [7:0]  match_cnt;
  logic [1:0]  dbg_state;
  logic        busy2, match2, ovf2, done2;
  logic [1:0]  match_cnt2;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  pattern_scan_ctrl u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_pat(cfg_pat), .cfg_plen(cfg_plen), .cfg_frame(cfg_frame),
    .data_in(data_in), .data_vld(data_vld),
    .busy(busy), .match(match), .match_cnt(match_cnt), .ovf(ovf),
    .done(done), .dbg_state(dbg_state)
  );

  pattern_scan_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_pat(cfg_pat), .cfg_plen(cfg_plen), .cfg_frame(cfg_frame),
    .data_in(data_in), .data_vld(data_vld),
    .busy(busy2), .match(match2), .match_cnt(match_cnt2), .ovf(ovf2),
    .done(done2), .dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_cnt"}, match_cnt, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] plen, input logic [15:0] frame);
    cfg_pat   = pat;
    cfg_plen  = plen;
    cfg_frame = frame;
    data_vld  = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // One valid bit; the expected match flag comes from the head of exp_q
  task automatic send_bit(input string tag, input logic b);
    logic [0:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    data_in  = b;
    data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
    check({tag, "_match"}, match, e);
  endtask

  // Send bits[0] first; with gap=1 an idle (vld=0, data_in=1) cycle follows
  // every bit but the last, and no pulse may appear there
  task automatic send_stream(input string tag, input logic [15:0] bits, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_bit(tag, bits[i]);
      if (gap && i != n - 1) begin
        data_in = 1'b1;
        tick();
        check({tag, "_gap_match"}, match, 0);
      end
    end
  endtask

  task automatic push_exp(input logic [15:0] m, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(m[i]);
  endtask

  initial begin
    // Test 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start    = 1'($urandom_range(0, 1));
      abort    = 1'($urandom_range(0, 1));
      data_in  = 1'($urandom_range(0, 1));
      data_vld = 1'($urandom_range(0, 1));
      cfg_pat  = 8'($urandom_range(0, 255));
      cfg_frame = 16'($urandom_range(0, 20));
      tick();
    end
    check_all_zero("rst");
    start = 0; abort = 0; data_vld = 0;
    rstn = 1'b1;
    tick(); tick();
    check_all_zero("post_rst");

    // Test 2: 010 over 0,1,0,1,0,0,1,0 -> matches after bits 3, 5, 8
    do_start(8'b010, 4'd3, 16'd8);
    check("t2_busy", busy, 1);
    check("t2_cnt0", match_cnt, 0);
    push_exp(16'b1001_0100, 8);
    send_stream("t2", 16'h004A, 8, 1'b0);
    check("t2_done", done, 1);
    check("t2_busy_end", busy, 0);
    check("t2_cnt", match_cnt, 3);
    tick();
    check("t2_done_gone", done, 0);
    check("t2_cnt_hold", match_cnt, 3);

    // Test 3: same stream, vld low every other cycle
    do_start(8'b010, 4'd3, 16'd8);
    push_exp(16'b1001_0100, 8);
    send_stream("t3", 16'h004A, 8, 1'b1);
    check("t3_done", done, 1);
    check("t3_cnt", match_cnt, 3);
    tick();

    // Test 4: all ones, pat=1 plen=1, frame=6; narrow counter saturates
    do_start(8'h01, 4'd1, 16'd6);
    push_exp(16'b11_1111, 6);
    send_stream("t4", 16'h003F, 6, 1'b0);
    check("t4_match2", match2, 1);
    check("t4_done", done, 1);
    check("t4_cnt", match_cnt, 6);
    check("t4_ovf", ovf, 0);
    check("t4_cnt2", match_cnt2, 3);
    check("t4_ovf2", ovf2, 1);
    tick();
    check("t4_ovf2_hold", ovf2, 1);

    // Test 5: 00 with plen=2; partial history, ignored start, abort
    do_start(8'h00, 4'd2, 16'd10);
    check("t5_cnt2_clr", match_cnt2, 0);
    check("t5_ovf2_clr", ovf2, 0);
    check("t5_busy", busy, 1);
    push_exp(16'b0010, 4);
    send_bit("t5_b1", 1'b0);
    send_bit("t5_b2", 1'b0);
    start = 1'b1; cfg_frame = 16'd1; cfg_plen = 4'd1;
    send_bit("t5_b3", 1'b1);
    start = 1'b0;
    check("t5_busy_after_start", busy, 1);
    send_bit("t5_b4", 1'b0);
    abort = 1'b1; data_in = 1'b0; data_vld = 1'b1;
    tick();
    abort = 1'b0; data_vld = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_match", match, 0);
    check("t5_abort_done", done, 0);
    check("t5_abort_cnt", match_cnt, 1);
    tick();
    check("t5_idle_done", done, 0);
    check("t5_idle_cnt", match_cnt, 1);

    // Test 6: plen=0 acts as 1, then async reset mid-run
    do_start(8'h01, 4'd0, 16'd5);
    push_exp(16'b101, 3);
    send_stream("t6", 16'b101, 3, 1'b0);
    check("t6_cnt", match_cnt, 2);
    rstn = 1'b0;
    #1;
    check_all_zero("t6_arst");
    tick();
    rstn = 1'b1;
    tick();
    check_all_zero("t6_after_rst");

    // frame=0 -> done the cycle after start
    do_start(8'h05, 4'd3, 16'd0);
    check("t6_f0_done", done, 1);
    check("t6_f0_busy", busy, 0);
    check("t6_f0_cnt", match_cnt, 0);
    tick();
    check("t6_f0_done_gone", done, 0);

    // plen above PAT_W clamps to 8: nine ones match only at bits 8 and 9
    do_start(8'hFF, 4'd15, 16'd9);
    push_exp(16'b1_1000_0000, 9);
    send_stream("t7", 16'h01FF, 9, 1'b0);
    check("t7_done", done, 1);
    check("t7_cnt", match_cnt, 2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
